// File: rtl/total_alu.sv
// total_alu: 32-bit MIPS-style ALU with single-cycle logic/arith ops and a
// sequential shift-add MULTU that writes an internal HI/LO pair read back via MFHI/MFLO.
// Optional restoring DIVU (code 27) is compiled in when TOTAL_ALU_DIVU_EN is defined.
module total_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Output
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] FnAnd   = 6'd36;
  localparam logic [5:0] FnOr    = 6'd37;
  localparam logic [5:0] FnAdd   = 6'd32;
  localparam logic [5:0] FnSub   = 6'd34;
  localparam logic [5:0] FnSlt   = 6'd42;
  localparam logic [5:0] FnSrl   = 6'd2;
  localparam logic [5:0] FnMfhi  = 6'd16;
  localparam logic [5:0] FnMflo  = 6'd18;
  localparam logic [5:0] FnMultu = 6'd25;
`ifdef TOTAL_ALU_DIVU_EN
  localparam logic [5:0] FnDivu  = 6'd27;
`endif

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e             state_q, state_d;
  logic [5:0]         prev_sig_q;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               start_mul, start_div;
  logic [WIDTH-1:0]   op_mcand;
  logic [2*WIDTH-1:0] op_prod;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_prod, step_prod;

  // Start detection and one iteration of the active algorithm. On a start edge the
  // iteration runs on the freshly captured operands instead of the registers.
  always_comb begin
    start_mul = (state_q == StIdle) && (Signal == FnMultu) && (prev_sig_q != FnMultu);
`ifdef TOTAL_ALU_DIVU_EN
    start_div = (state_q == StIdle) && (Signal == FnDivu) && (prev_sig_q != FnDivu);
`else
    start_div = 1'b0;
`endif
    op_mcand = mcand_q;
    op_prod  = prod_q;
    if (start_mul) begin
      op_mcand = dataA;
      op_prod  = {{WIDTH{1'b0}}, dataB};
    end else if (start_div) begin
      op_mcand = dataB;
      op_prod  = {{WIDTH{1'b0}}, dataA};
    end
    mul_sum = {1'b0, op_prod[2*WIDTH-1:WIDTH]};
    if (op_prod[0]) mul_sum = mul_sum + {1'b0, op_mcand};
    mul_prod  = {mul_sum, op_prod[WIDTH-1:1]};
    step_prod = mul_prod;
  end

`ifdef TOTAL_ALU_DIVU_EN
  logic [WIDTH:0]     div_tmp;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_prod;
  logic               do_div;

  // Restoring divide step on prod = {remainder, dividend/quotient}. A zero divisor
  // always "fits", so the remainder ends up holding the dividend and the quotient all ones.
  always_comb begin
    div_tmp  = op_prod[2*WIDTH-1:WIDTH-1];
    div_diff = {1'b0, div_tmp} - {2'b00, op_mcand};
    div_ge   = ~div_diff[WIDTH+1];
    div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0];
    div_prod = {div_rem, op_prod[WIDTH-2:0], div_ge};
    do_div   = start_div || (state_q == StDiv);
  end
`endif

  // Sequencer next state: start, iterate, and commit HI/LO on the last iteration.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (start_mul || start_div) begin
          state_d = start_mul ? StMul : StDiv;
          mcand_d = op_mcand;
          prod_d  = step_prod;
          count_d = CntW'(1);
        end
      end
      StMul, StDiv: begin
        prod_d  = step_prod;
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          hi_d    = step_prod[2*WIDTH-1:WIDTH];
          lo_d    = step_prod[WIDTH-1:0];
          state_d = StIdle;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef TOTAL_ALU_DIVU_EN
    if (do_div) begin
      prod_d = (state_q == StIdle || count_q != CntW'(WIDTH - 1)) ? div_prod : prod_d;
      if (state_q == StDiv && count_q == CntW'(WIDTH - 1)) begin
        hi_d = div_prod[2*WIDTH-1:WIDTH];
        lo_d = div_prod[WIDTH-1:0];
      end
    end
`endif
  end

  // State registers with synchronous reset; reset aborts any running operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      prev_sig_q <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      prev_sig_q <= Signal;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // Combinational result mux; forced to zero while reset is held.
  always_comb begin
    Output = '0;
    if (!reset) begin
      case (Signal)
        FnAnd:   Output = dataA & dataB;
        FnOr:    Output = dataA | dataB;
        FnAdd:   Output = dataA + dataB;
        FnSub:   Output = dataA - dataB;
        FnSlt:   Output = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
        FnSrl:   Output = dataA >> dataB[CntW-1:0];
        FnMfhi:  Output = hi_q;
        FnMflo:  Output = lo_q;
        FnMultu: Output = '0;
        default: Output = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_total_alu.sv
// Self-checking bench for total_alu: table of combinational vectors plus
// hand-written MULTU / reset / DIVU sequences with hand-computed results.
module tb_total_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB, Output;
  logic [5:0]  Signal;

  int n_tests = 0;
  int n_fail  = 0;

  total_alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .Output (Output)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  sig;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, got, got, exp, exp);
    end
  endtask

  task automatic apply(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
    Signal = s;
    dataA  = a;
    dataB  = b;
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{6'd36, 32'd4042322160, 32'd4294901760, 32'd4042260480};
    vecs[1]  = '{6'd37, 32'd4042322160, 32'd4294901760, 32'd4294963440};
    vecs[2]  = '{6'd32, 32'd4294967295, 32'd1,          32'd0};
    vecs[3]  = '{6'd32, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000};
    vecs[4]  = '{6'd34, 32'd3,          32'd5,          32'd4294967294};
    vecs[5]  = '{6'd34, 32'd0,          32'd1,          32'hFFFF_FFFF};
    vecs[6]  = '{6'd42, 32'd4294967295, 32'd1,          32'd1};
    vecs[7]  = '{6'd42, 32'd1,          32'd4294967295, 32'd0};
    vecs[8]  = '{6'd42, 32'hFFFF_FFFB,  32'hFFFF_FFFD,  32'd1};
    vecs[9]  = '{6'd2,  32'd256,        32'd4,          32'd16};
    vecs[10] = '{6'd2,  32'h8000_0000,  32'd31,         32'd1};
    vecs[11] = '{6'd2,  32'd256,        32'd36,         32'd16};
    vecs[12] = '{6'd63, 32'd7,          32'd9,          32'd0};
    vecs[13] = '{6'd16, 32'd7,          32'd9,          32'd0};
    vecs[14] = '{6'd18, 32'd7,          32'd9,          32'd0};
    vecs[15] = '{6'd25, 32'd5,          32'd6,          32'd0};

    reset = 1'b1;
    apply(6'd32, 32'd1, 32'd1);
    tick(2);
    check("reset_output_zero", Output, 32'd0);
    reset = 1'b0;
    tick(1);

    // Combinational table; the last entry (MULTU 5*6) starts a multiply.
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].sig, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_sig%0d", i, vecs[i].sig), Output, vecs[i].exp);
    end
    tick(40);
    apply(6'd18, 32'd0, 32'd0);
    check("multu_5x6_lo", Output, 32'd30);
    apply(6'd16, 32'd0, 32'd0);
    check("multu_5x6_hi", Output, 32'd0);

    // MULTU 100000*100000 with exact latency: result lands on the 32nd edge.
    apply(6'd0, 32'd0, 32'd0);
    tick(1);
    apply(6'd25, 32'd100000, 32'd100000);
    tick(31);
    apply(6'd18, 32'd100000, 32'd100000);
    check("multu1_lo_before_done", Output, 32'd30);
    tick(1);
    check("multu1_lo", Output, 32'd1410065408);
    apply(6'd16, 32'd0, 32'd0);
    check("multu1_hi", Output, 32'd2);

    // MULTU max*max with mid-run reads, operand changes and a re-issued start.
    apply(6'd0, 32'd0, 32'd0);
    tick(1);
    apply(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(5);
    apply(6'd16, 32'd3, 32'd3);
    check("mid_mul_hi_old", Output, 32'd2);
    apply(6'd32, 32'd3, 32'd3);
    check("mid_mul_add", Output, 32'd6);
    apply(6'd25, 32'd3, 32'd3);
    tick(27);
    tick(40);
    apply(6'd16, 32'd3, 32'd3);
    check("multu2_hi", Output, 32'd4294967294);
    apply(6'd18, 32'd3, 32'd3);
    check("multu2_lo", Output, 32'd1);

`ifdef TOTAL_ALU_DIVU_EN
    apply(6'd0, 32'd0, 32'd0);
    tick(1);
    apply(6'd27, 32'd100, 32'd7);
    check("divu_output_zero", Output, 32'd0);
    tick(32);
    apply(6'd18, 32'd0, 32'd0);
    check("divu_lo", Output, 32'd14);
    apply(6'd16, 32'd0, 32'd0);
    check("divu_hi", Output, 32'd2);
    apply(6'd0, 32'd0, 32'd0);
    tick(1);
    apply(6'd27, 32'd12345, 32'd0);
    tick(32);
    apply(6'd18, 32'd0, 32'd0);
    check("divu0_lo", Output, 32'hFFFF_FFFF);
    apply(6'd16, 32'd0, 32'd0);
    check("divu0_hi", Output, 32'd12345);
    // Restore HI/LO to the MULTU result for the reset test below.
    apply(6'd0, 32'd0, 32'd0);
    tick(1);
    apply(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(33);
`else
    apply(6'd0, 32'd0, 32'd0);
    tick(1);
    apply(6'd27, 32'd9, 32'd9);
    check("code27_output_zero", Output, 32'd0);
    tick(40);
    apply(6'd18, 32'd0, 32'd0);
    check("code27_no_state_change", Output, 32'd1);
`endif

    // Reset mid-MULTU aborts the operation and clears HI/LO.
    apply(6'd0, 32'd0, 32'd0);
    tick(1);
    apply(6'd25, 32'd7, 32'd6);
    tick(5);
    reset = 1'b1;
    tick(1);
    check("reset_mid_output", Output, 32'd0);
    reset = 1'b0;
    apply(6'd16, 32'd0, 32'd0);
    check("reset_mid_hi", Output, 32'd0);
    apply(6'd18, 32'd0, 32'd0);
    check("reset_mid_lo", Output, 32'd0);
    tick(40);
    check("reset_abort_no_write", Output, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
